// File: rtl/gate_identifier.sv
// gate_identifier
//   Watches (a, b, c) samples from an unknown 2-input gate. It builds the gate's
//   truth table and names the library gate that produced it.
//   id_code: 0 AND, 1 OR, 2 NOR, 3 NAND, 4 XOR, 5 XNOR, 7 NONE.
//
//   Optional build macro GATE_ID_EARLY_EN: when it is defined, COLLECT also
//   finishes as soon as the candidate mask is one-hot or empty. Without it, DONE
//   needs all four rows.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            1-cycle pulse: clear the table and enter COLLECT (any state)
//   sample_valid     sample_a/b/c are valid this cycle
//   sample_a/b       gate inputs; sample_c is the observed gate output
//   sample_ready     a sample is accepted this cycle if valid (COLLECT, no start)
//   id_valid         high while in DONE
//   id_code          identified gate (held in DONE)
//   cand_mask        bit i = gate i is consistent with every row seen so far
//   conflict         high while in ERROR (same row seen with two outputs)
//   timeout          high while in TIMEOUT (MAX_SAMPLES accepted, table incomplete)
//   sample_count     samples accepted since the last start
module gate_identifier #(
  parameter int MAX_SAMPLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             sample_a,
  input  logic             sample_b,
  input  logic             sample_c,
  output logic             sample_ready,
  output logic             id_valid,
  output logic [2:0]       id_code,
  output logic [5:0]       cand_mask,
  output logic             conflict,
  output logic             timeout,
  output logic [CNT_W-1:0] sample_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_DONE, S_ERROR, S_TIMEOUT
  } state_t;

  state_t     state;
  logic [3:0] seen, val;

  // Truth tables of the six library gates, val[3:0] = rows 11,10,01,00.
  function automatic logic [3:0] gate_tt(input int i);
    case (i)
      0:       return 4'b1000; // AND
      1:       return 4'b1110; // OR
      2:       return 4'b0001; // NOR
      3:       return 4'b0111; // NAND
      4:       return 4'b0110; // XOR
      default: return 4'b1001; // XNOR
    endcase
  endfunction

  function automatic logic [5:0] cand_of(input logic [3:0] s, input logic [3:0] v);
    logic [5:0] m;
    for (int i = 0; i < 6; i++)
      m[i] = (((v ^ gate_tt(i)) & s) == 4'b0000);
    return m;
  endfunction

  // The index of the lowest set bit, or 7 when no gate is left.
  function automatic logic [2:0] id_of(input logic [5:0] m);
    logic [2:0] id;
    id = 3'd7;
    for (int i = 5; i >= 0; i--)
      if (m[i]) id = 3'(i);
    return id;
  endfunction

  logic             accept, clash, finish;
  logic [1:0]       row;
  logic [3:0]       seen_nx, val_nx;
  logic [5:0]       mask_nx;
  logic [CNT_W-1:0] cnt_nx;

  assign sample_ready = (state == S_COLLECT) && !start;
  assign accept       = sample_valid && sample_ready;
  assign row          = {sample_a, sample_b};
  assign clash        = seen[row] && (val[row] != sample_c);
  assign cnt_nx       = sample_count + 1'b1;

  // The post-update table. A duplicate row with the same c leaves it unchanged.
  always_comb begin
    seen_nx      = seen;
    val_nx       = val;
    seen_nx[row] = 1'b1;
    val_nx[row]  = sample_c;
  end

  assign mask_nx = cand_of(seen_nx, val_nx);

`ifdef GATE_ID_EARLY_EN
  assign finish = (&seen_nx) || $onehot0(mask_nx);
`else
  assign finish = &seen_nx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      seen         <= '0;
      val          <= '0;
      id_code      <= '0;
      cand_mask    <= 6'h3F;
      sample_count <= '0;
    end else if (start) begin
      state        <= S_COLLECT;
      seen         <= '0;
      val          <= '0;
      id_code      <= '0;
      cand_mask    <= 6'h3F;
      sample_count <= '0;
    end else if (accept) begin
      sample_count <= cnt_nx;
      if (clash) begin
        state <= S_ERROR;            // the table keeps its last consistent contents
      end else begin
        seen      <= seen_nx;
        val       <= val_nx;
        cand_mask <= mask_nx;
        if (finish) begin
          state   <= S_DONE;
          id_code <= id_of(mask_nx);
        end else if (cnt_nx == CNT_W'(MAX_SAMPLES)) begin
          state <= S_TIMEOUT;
        end
      end
    end
  end

  assign id_valid = (state == S_DONE);
  assign conflict = (state == S_ERROR);
  assign timeout  = (state == S_TIMEOUT);

endmodule
